// File: rtl/mem_ctrl.sv
// Data-side memory controller: latches one issued memory op, runs it on the
// SRAM-like data bus and returns aligned/extended load data to commit.
module mem_ctrl #(
  parameter int unsigned PREG_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_issued,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [PREG_WIDTH-1:0] req_preg,
  input  logic                  flush,
  output logic                  wait_mem,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [31:0]           data_addr,
  output logic [31:0]           data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [31:0]           data_rdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic [PREG_WIDTH-1:0] resp_preg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state;
  logic   sgn_q;

  // Select the addressed byte/half of the bus word and extend it to 32 bits.
  function automatic logic [31:0] align_load(input logic        wr,
                                             input logic [1:0]  size,
                                             input logic        sgn,
                                             input logic [1:0]  off,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> {off, 3'b000});
    h = 16'(rdata >> {off[1], 4'b0000});
    if (wr) return 32'd0;
    case (size)
      2'd0:    return sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'd1:    return sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  // Stores are replicated across the bus so any byte lane carries the data.
  function automatic logic [31:0] replicate(input logic [1:0]  size,
                                            input logic [31:0] wdata);
    case (size)
      2'd0:    return {4{wdata[7:0]}};
      2'd1:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  assign wait_mem   = (state != IDLE);
  assign data_req   = (state == REQ);
  assign resp_valid = (state == RESP) && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sgn_q      <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'd0;
      data_wdata <= 32'd0;
      resp_data  <= 32'd0;
      resp_preg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_issued && !flush) begin
            state      <= REQ;
            data_wr    <= req_wr;
            data_size  <= (req_size == 2'd3) ? 2'd2 : req_size;
            data_addr  <= req_addr;
            data_wdata <= replicate(req_size, req_wdata);
            sgn_q      <= req_signed;
            resp_preg  <= req_preg;
          end
        end
        REQ: begin
          // An unaccepted request may be withdrawn; an accepted one must drain.
          if (flush) begin
            state <= (data_addr_ok && !data_data_ok) ? DRAIN : IDLE;
          end else if (data_addr_ok) begin
            if (data_data_ok) begin
              state     <= RESP;
              resp_data <= align_load(data_wr, data_size, sgn_q, data_addr[1:0], data_rdata);
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (flush) begin
            state <= data_data_ok ? IDLE : DRAIN;
          end else if (data_data_ok) begin
            state     <= RESP;
            resp_data <= align_load(data_wr, data_size, sgn_q, data_addr[1:0], data_rdata);
          end
        end
        RESP: state <= IDLE;
        DRAIN: begin
          if (data_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table, directed corner sequences
// and randomized transactions against a transaction-level reference.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_issued, req_wr, req_signed, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [5:0]  req_preg;
  logic        wait_mem, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [5:0]  resp_preg;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.PREG_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .mem_issued(mem_issued), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_preg(req_preg), .flush(flush),
    .wait_mem(wait_mem), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_preg(resp_preg)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_size;
    logic [31:0] exp_resp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    mem_issued = 0; flush = 0; data_addr_ok = 0; data_data_ok = 0;
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [5:0] preg);
    mem_issued = 1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_preg = preg;
  endtask

  // Reference: extract the addressed field by plain shifting, then extend.
  function automatic logic [31:0] ref_result(input logic wr, input logic [1:0] size,
                                             input logic sgn, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int unsigned nbytes, shift;
    logic [63:0] mask, val;
    if (wr) return 32'd0;
    nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    shift  = 8 * ((addr % 4) - (addr % nbytes));
    mask   = (64'd1 << (8 * nbytes)) - 64'd1;
    val    = (64'(rdata) >> shift) & mask;
    if (sgn && val > (mask >> 1)) val = val | ~mask;
    return val[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wdata);
    int unsigned nbytes;
    logic [63:0] pat, r;
    nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    pat = 64'(wdata) % (64'd1 << (8 * nbytes));
    r = 64'd0;
    for (int i = 0; i < 4 / nbytes; i++) r = r | (pat << (8 * nbytes * i));
    return r[31:0];
  endfunction

  // Minimum-latency op: addr_ok and data_ok both the cycle after issue.
  task automatic run_vec(input vec_t v, input logic [5:0] preg);
    issue(v.wr, v.size, v.sgn, v.addr, v.wdata, preg);
    sample(); check("idle_before_issue", 32'(wait_mem), 0);
    next();
    quiet(); data_addr_ok = 1; data_data_ok = 1; data_rdata = v.rdata;
    sample();
    check("req_data_req", 32'(data_req), 1);
    check("req_wait_mem", 32'(wait_mem), 1);
    check("req_data_wr", 32'(data_wr), 32'(v.wr));
    check("req_data_size", 32'(data_size), 32'(v.exp_size));
    check("req_data_addr", data_addr, v.addr);
    check("req_data_wdata", data_wdata, v.exp_wdata);
    next();
    quiet();
    sample();
    check("resp_valid", 32'(resp_valid), 1);
    check("resp_data", resp_data, v.exp_resp);
    check("resp_preg", 32'(resp_preg), 32'(preg));
    next();
  endtask

  initial begin
    int k, a, d, r, nresp;
    logic dropped, withdrawn, exp_resp;
    logic [31:0] exp_data;

    vecs[0] = '{0, 2'd2, 0, 32'h1000, 32'h0, 32'hDEADBEEF, 32'h0, 2'd2, 32'hDEADBEEF};
    vecs[1] = '{0, 2'd0, 1, 32'h1003, 32'h0, 32'h80FF1234, 32'h0, 2'd0, 32'hFFFFFF80};
    vecs[2] = '{0, 2'd0, 0, 32'h1003, 32'h0, 32'h80FF1234, 32'h0, 2'd0, 32'h00000080};
    vecs[3] = '{1, 2'd1, 0, 32'h2002, 32'h0000ABCD, 32'h55555555, 32'hABCDABCD, 2'd1, 32'h0};
    vecs[4] = '{1, 2'd0, 0, 32'h3001, 32'h12345678, 32'hFFFFFFFF, 32'h78787878, 2'd0, 32'h0};
    vecs[5] = '{0, 2'd1, 1, 32'h4002, 32'h0, 32'h80017FFF, 32'h0, 2'd1, 32'hFFFF8001};
    vecs[6] = '{0, 2'd1, 0, 32'h4000, 32'h0, 32'h1234F00D, 32'h0, 2'd1, 32'h0000F00D};
    vecs[7] = '{0, 2'd3, 1, 32'h5000, 32'h0, 32'hCAFEF00D, 32'h0, 2'd2, 32'hCAFEF00D};
    vecs[8] = '{0, 2'd0, 1, 32'h6001, 32'h0, 32'h00007F00, 32'h0, 2'd0, 32'h0000007F};
    vecs[9] = '{1, 2'd2, 0, 32'h7000, 32'h11223344, 32'h0, 32'h11223344, 2'd2, 32'h0};

    reset = 1; quiet(); req_wr = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; req_preg = 0; data_rdata = 0;
    next(); next();
    sample();
    check("rst_wait_mem", 32'(wait_mem), 0);
    check("rst_data_req", 32'(data_req), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_data_addr", data_addr, 0);
    check("rst_resp_data", resp_data, 0);
    next();
    reset = 0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 6'(i + 1));

    // Word load with one WAIT cycle.
    issue(0, 2'd2, 0, 32'h1000, 32'h0, 6'd5); next();
    quiet(); data_addr_ok = 1; sample();
    check("wl_t1_wait", 32'(wait_mem), 1); check("wl_t1_req", 32'(data_req), 1); next();
    quiet(); sample();
    check("wl_t2_wait", 32'(wait_mem), 1); check("wl_t2_req", 32'(data_req), 0);
    check("wl_t2_resp", 32'(resp_valid), 0); next();
    data_data_ok = 1; data_rdata = 32'hDEADBEEF; sample();
    check("wl_t3_wait", 32'(wait_mem), 1); check("wl_t3_resp", 32'(resp_valid), 0); next();
    quiet(); sample();
    check("wl_t4_resp", 32'(resp_valid), 1); check("wl_t4_data", resp_data, 32'hDEADBEEF);
    check("wl_t4_preg", 32'(resp_preg), 5); check("wl_t4_wait", 32'(wait_mem), 1); next();
    sample(); check("wl_t5_wait", 32'(wait_mem), 0); check("wl_t5_resp", 32'(resp_valid), 0); next();

    // Flush in WAIT, data arrives two cycles later and is discarded.
    issue(0, 2'd2, 0, 32'h1100, 32'h0, 6'd9); next();
    quiet(); data_addr_ok = 1; next();
    quiet(); flush = 1; next();
    quiet(); sample();
    check("fw_drain_wait", 32'(wait_mem), 1); check("fw_drain_req", 32'(data_req), 0); next();
    data_data_ok = 1; data_rdata = 32'h12345678; sample();
    check("fw_dok_resp", 32'(resp_valid), 0); check("fw_dok_wait", 32'(wait_mem), 1); next();
    quiet(); sample();
    check("fw_after_resp", 32'(resp_valid), 0); check("fw_after_wait", 32'(wait_mem), 0); next();
    run_vec(vecs[1], 6'd17);

    // Flush in REQ without acceptance withdraws the request.
    issue(0, 2'd2, 0, 32'h1200, 32'h0, 6'd3); next();
    quiet(); flush = 1; sample(); check("fr_req", 32'(data_req), 1); next();
    quiet(); sample();
    check("fr_next_req", 32'(data_req), 0); check("fr_next_wait", 32'(wait_mem), 0);
    check("fr_next_resp", 32'(resp_valid), 0); next();

    // Flush coincident with acceptance drains.
    issue(0, 2'd2, 0, 32'h1300, 32'h0, 6'd4); next();
    quiet(); flush = 1; data_addr_ok = 1; next();
    quiet(); sample();
    check("fa_drain_req", 32'(data_req), 0); check("fa_drain_wait", 32'(wait_mem), 1); next();
    data_data_ok = 1; sample(); check("fa_dok_resp", 32'(resp_valid), 0); next();
    quiet(); sample();
    check("fa_done_wait", 32'(wait_mem), 0); check("fa_done_resp", 32'(resp_valid), 0); next();

    // Flush in RESP suppresses the pulse.
    issue(0, 2'd2, 0, 32'h1400, 32'h0, 6'd6); next();
    quiet(); data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1; next();
    quiet(); flush = 1; sample(); check("fresp_resp", 32'(resp_valid), 0); next();
    quiet(); sample(); check("fresp_wait", 32'(wait_mem), 0); next();

    // New issue while busy is ignored.
    issue(0, 2'd2, 0, 32'h0100, 32'h0, 6'd7); next();
    issue(1, 2'd0, 0, 32'h0200, 32'hFF, 6'd8); next();
    quiet(); data_addr_ok = 1; sample(); check("busy_addr", data_addr, 32'h0100); next();
    quiet(); data_data_ok = 1; data_rdata = 32'hA5A5A5A5; next();
    quiet(); sample();
    check("busy_resp", 32'(resp_valid), 1); check("busy_preg", 32'(resp_preg), 7);
    check("busy_data", resp_data, 32'hA5A5A5A5); next();

    // Reset in WAIT clears everything; a stray data_ok is ignored.
    issue(1, 2'd2, 0, 32'h9000, 32'h87654321, 6'd33); next();
    quiet(); data_addr_ok = 1; next();
    quiet(); reset = 1; next();
    reset = 0; data_data_ok = 1; sample();
    check("rw_wait", 32'(wait_mem), 0); check("rw_req", 32'(data_req), 0);
    check("rw_wr", 32'(data_wr), 0); check("rw_size", 32'(data_size), 0);
    check("rw_addr", data_addr, 0); check("rw_wdata", data_wdata, 0);
    check("rw_resp", 32'(resp_valid), 0); check("rw_rdata", resp_data, 0);
    check("rw_preg", 32'(resp_preg), 0); next();
    quiet(); sample();
    check("rw_stray_resp", 32'(resp_valid), 0); check("rw_stray_wait", 32'(wait_mem), 0); next();

    // Randomized transactions with random bus latency and flush timing.
    for (int t = 0; t < 200; t++) begin
      req_wr = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_preg = 6'($urandom);
      k = $urandom_range(0, 9);
      if (k == 0) k = 0;
      else if (k <= 3) k = $urandom_range(1, 6);
      else k = -1;
      a = $urandom_range(0, 2);
      d = $urandom_range(0, 2);
      if (k == 1 + a && d == 0) d = 1;
      r = 2 + a + d;
      dropped = (k == 0);
      withdrawn = (k >= 1 && k < 1 + a);
      exp_resp = !dropped && !withdrawn && (k < 0 || k > r);
      nresp = 0;
      exp_data = 32'd0;
      for (int c = 0; c <= r + 1; c++) begin
        mem_issued = (c == 0);
        flush = (c == k);
        data_addr_ok = !dropped && !withdrawn && (c == 1 + a);
        data_data_ok = !dropped && !withdrawn && (c == 1 + a + d);
        data_rdata = $urandom;
        if (c == 1 + a + d) exp_data = ref_result(req_wr, req_size, req_signed, req_addr, data_rdata);
        sample();
        if (c == 1 && !dropped) check("rnd_wdata", data_wdata, ref_wdata(req_size, req_wdata));
        if (c == 1 && dropped) check("rnd_dropped_req", 32'(data_req), 0);
        if (resp_valid) begin
          nresp++;
          check("rnd_resp_data", resp_data, exp_data);
          check("rnd_resp_preg", 32'(resp_preg), 32'(req_preg));
        end
        if (c == r + 1) check("rnd_end_wait", 32'(wait_mem), 0);
        next();
      end
      quiet();
      check("rnd_resp_count", 32'(nresp), exp_resp ? 1 : 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Data-side memory controller for the out-of-order core: the responder end of the issue-stage memory handshake. Each memory op launched by issue (`mem_issued`) is latched here, driven onto the SRAM-like data bus, and its load data is aligned and extended. The result is returned to commit with its destination physical register. `wait_mem` holds off further memory issue while an op is in flight; at most one op is outstanding.

## Interface
- `PREG_WIDTH`, 6, physical register address width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `mem_issued`  in  1  issue launches a memory op this cycle; request fields are valid
- `req_wr`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
- `req_signed`  in  1  sign-extend load data
- `req_addr`  in  32  byte address; alignment already checked upstream
- `req_wdata`  in  32  store data, low-aligned
- `req_preg`  in  PREG_WIDTH  destination physical register
- `flush`  in  1  pipeline flush (branch mispredict or exception)
- `wait_mem`  out  1  controller busy; issue must not assert `mem_issued`
- `data_req`  out  1  bus request
- `data_wr`, `data_size[1:0]`, `data_addr[31:0]`, `data_wdata[31:0]`  out  bus request fields
- `data_addr_ok`  in  1  bus accepted the request
- `data_data_ok`  in  1  bus completed; `data_rdata` valid
- `data_rdata`  in  32  read data
- `resp_valid`  out  1  one-cycle result pulse to commit
- `resp_data`  out  32  aligned and extended load data; 0 for stores
- `resp_preg`  out  PREG_WIDTH  destination physical register

## Operation
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- Request fields are registered on `mem_issued` in IDLE. All bus outputs are driven from these registers.
- IDLE:
  - `mem_issued & !flush` → REQ.
  - `mem_issued & flush` is dropped.
  - `mem_issued` in any other state is ignored.
- REQ: `data_req`=1.
  - `flush & !data_addr_ok` → IDLE. The request is withdrawn, which the bus permits.
  - `flush & data_addr_ok` → DRAIN.
  - `data_addr_ok & data_data_ok` → RESP, capture rdata.
  - `data_addr_ok` alone → WAIT.
- WAIT:
  - `data_data_ok` → RESP, capture rdata.
  - With `flush`: go to IDLE if `data_data_ok` in the same cycle, else DRAIN.
- RESP:
  - `resp_valid = !flush`; always → IDLE.
- DRAIN: `data_req`=0. On `data_data_ok` → IDLE; the data is discarded and no response is issued.
- `wait_mem` = (state != IDLE), driven from state flops.
- Store data replication on `data_wdata`:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: as-is
- `data_addr` = `req_addr`, unmodified.
- Load alignment, with `off = addr[1:0]`:
  - byte: `rdata[8*off +: 8]`
  - half: `rdata[16*addr[1] +: 16]`
  - word: `rdata`
  - Sign-extend if `req_signed`, else zero-extend.
  - Alignment is computed when `data_data_ok` arrives and registered into `resp_data`.
- Stores still pulse `resp_valid` with `resp_data`=0, so the ROB can complete them.

## Timing
- Reset values: state=IDLE; `wait_mem`, `data_req`, `resp_valid` = 0; all data/address/preg outputs = 0.
- Reset mid-operation: next cycle is IDLE with no response. Any late `data_data_ok` in IDLE is ignored.
- Cycle T `mem_issued` → T+1 `data_req`=1 and `wait_mem`=1.
- With `addr_ok` at T+1 and `data_ok` at T+2: `resp_valid` at T+3, `wait_mem`=0 at T+4.
- Minimum latency, `mem_issued` to `resp_valid`: 2 cycles (`addr_ok` and `data_ok` both at T+1).
- Minimum back-to-back issue spacing: `wait_mem` falls the cycle after RESP, so the next `mem_issued` can come at T+3 in that case.
- `data_req` and its fields stay stable from REQ entry until `data_addr_ok`.
- `data_data_ok` outside WAIT, REQ (with `addr_ok`) and DRAIN is ignored.

## Test plan
- Word load: addr 0x1000, `addr_ok` at T+1, `data_ok` at T+3 with rdata 0xDEADBEEF → `resp_valid` at T+4, data 0xDEADBEEF, correct preg; `wait_mem` high T+1..T+4.
- Signed byte load at addr 0x1003, rdata 0x80FF_1234 → `resp_data` 0xFFFFFF80. Unsigned variant → 0x00000080.
- Half store at addr 0x2002, wdata 0x0000ABCD → `data_wdata` 0xABCDABCD, `data_size` 1, `data_wr` 1; `resp_valid` with `resp_data` 0.
- Flush in WAIT, `data_ok` 2 cycles later → no `resp_valid`; `wait_mem` drops the cycle after `data_ok`; a new load then completes normally.
- Flush in REQ without `addr_ok` → `data_req` 0 next cycle, state IDLE; flush coincident with `addr_ok` → DRAIN and discard.
- Reset asserted in WAIT → all outputs 0 next cycle; a subsequent stray `data_ok` produces no response.
